// File: rtl/isw_and_seq_if.sv
// Bundle of operand, randomness, gadget, result and status signals for isw_and_seq.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface isw_and_seq_if #(
  parameter int WIDTH = 8
);
  // Operand handshake and shares
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] x0_i;
  logic [WIDTH-1:0] x1_i;
  logic [WIDTH-1:0] y0_i;
  logic [WIDTH-1:0] y1_i;

  // Fresh randomness
  logic             rnd_valid_i;
  logic             rnd_ready_o;
  logic [WIDTH-1:0] rnd_i;

  // Gadget drive and gadget result
  logic [WIDTH-1:0] g_x0_o;
  logic [WIDTH-1:0] g_x1_o;
  logic [WIDTH-1:0] g_y0_o;
  logic [WIDTH-1:0] g_y1_o;
  logic [WIDTH-1:0] g_r01_o;
  logic             g_rst_o;
  logic [WIDTH-1:0] g_q0_i;
  logic [WIDTH-1:0] g_q1_i;

  // Result handshake and shares
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] q0_o;
  logic [WIDTH-1:0] q1_o;

  // Status
  logic             busy_o;
  logic [15:0]      op_cnt_o;

  modport slave (
    input  in_valid_i, x0_i, x1_i, y0_i, y1_i,
    input  rnd_valid_i, rnd_i,
    input  g_q0_i, g_q1_i,
    input  out_ready_i,
    output in_ready_o, rnd_ready_o,
    output g_x0_o, g_x1_o, g_y0_o, g_y1_o, g_r01_o, g_rst_o,
    output out_valid_o, q0_o, q1_o,
    output busy_o, op_cnt_o
  );

  modport master (
    output in_valid_i, x0_i, x1_i, y0_i, y1_i,
    output rnd_valid_i, rnd_i,
    output g_q0_i, g_q1_i,
    output out_ready_i,
    input  in_ready_o, rnd_ready_o,
    input  g_x0_o, g_x1_o, g_y0_o, g_y1_o, g_r01_o, g_rst_o,
    input  out_valid_o, q0_o, q1_o,
    input  busy_o, op_cnt_o
  );
endinterface

// File: rtl/isw_and_seq.sv
// Sequencer driving a 2-share ISW AND gadget: joint operand/randomness accept, 3-cycle issue, registered result.
// Optional macro ISW_SEQ_ZERO_IDLE_EN: blank the gadget share/randomness buses while IDLE.
module isw_and_seq #(
  parameter int WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  isw_and_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             g_rst_q, g_rst_d;
  logic [WIDTH-1:0] x0_q, x0_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] y0_q, y0_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q0_q, q0_d;
  logic [WIDTH-1:0] q1_q, q1_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      op_cnt_q, op_cnt_d;

  logic can_accept;
  logic accept;
  logic out_hs;
  logic in_ready;
  logic rnd_ready;
  logic g_drive;

  // Operand and randomness only move together, so each word is bound to exactly one operation.
  always_comb begin
    can_accept = (state_q == IDLE) && !out_valid_q && !g_rst_q;
    in_ready   = can_accept && bus.rnd_valid_i;
    rnd_ready  = can_accept && bus.in_valid_i;
    accept     = can_accept && bus.in_valid_i && bus.rnd_valid_i;
    out_hs     = out_valid_q && bus.out_ready_i;
  end

  always_comb begin
    state_d     = state_q;
    g_rst_d     = 1'b0;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    r_d         = r_q;
    q0_d        = q0_q;
    q1_d        = q1_q;
    out_valid_d = out_valid_q;
    op_cnt_d    = op_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          x0_d    = bus.x0_i;
          x1_d    = bus.x1_i;
          y0_d    = bus.y0_i;
          y1_d    = bus.y1_i;
          r_d     = bus.rnd_i;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = HOLD;
      HOLD:  state_d = DONE;
      DONE: begin
        // Gadget output still depends on g_r01 here, so sample before leaving DONE.
        q0_d        = bus.g_q0_i;
        q1_d        = bus.g_q1_i;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (out_hs) begin
      out_valid_d = 1'b0;
      if (op_cnt_q != 16'hFFFF) begin
        op_cnt_d = op_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      g_rst_q     <= 1'b1;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      r_q         <= '0;
      q0_q        <= '0;
      q1_q        <= '0;
      out_valid_q <= 1'b0;
      op_cnt_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      g_rst_q     <= g_rst_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      r_q         <= r_d;
      q0_q        <= q0_d;
      q1_q        <= q1_d;
      out_valid_q <= out_valid_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

`ifdef ISW_SEQ_ZERO_IDLE_EN
  assign g_drive = (state_q != IDLE);
`else
  assign g_drive = 1'b1;
`endif

  always_comb begin
    bus.g_x0_o  = g_drive ? x0_q : '0;
    bus.g_x1_o  = g_drive ? x1_q : '0;
    bus.g_y0_o  = g_drive ? y0_q : '0;
    bus.g_y1_o  = g_drive ? y1_q : '0;
    bus.g_r01_o = g_drive ? r_q  : '0;
  end

  assign bus.g_rst_o     = g_rst_q;
  assign bus.in_ready_o  = in_ready;
  assign bus.rnd_ready_o = rnd_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.q0_o        = q0_q;
  assign bus.q1_o        = q1_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.op_cnt_o    = op_cnt_q;

endmodule

// File: tb/tb_isw_and_seq.sv
// Self-checking bench for isw_and_seq with a behavioural 2-share ISW AND gadget attached.
// Expected results come from X&Y arithmetic and a saturating handshake counter.
module tb_isw_and_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  isw_and_seq_if #(.WIDTH(W)) bus ();

  isw_and_seq #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Gadget: registered cross-domain term, output combinational in r01.
  logic [W-1:0] cross_q;
  always_ff @(posedge clk) begin
    if (bus.g_rst_o) cross_q <= '0;
    else cross_q <= bus.g_r01_o ^ (bus.g_x0_o & bus.g_y1_o) ^ (bus.g_x1_o & bus.g_y0_o);
  end
  assign bus.g_q0_i = (bus.g_x0_o & bus.g_y0_o) ^ bus.g_r01_o;
  assign bus.g_q1_i = (bus.g_x1_o & bus.g_y1_o) ^ cross_q;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_g(input logic [W-1:0] x0, x1, y0, y1, r);
`ifdef ISW_SEQ_ZERO_IDLE_EN
    check("idle_g_x0", bus.g_x0_o, 0);
    check("idle_g_x1", bus.g_x1_o, 0);
    check("idle_g_y0", bus.g_y0_o, 0);
    check("idle_g_y1", bus.g_y1_o, 0);
    check("idle_g_r01", bus.g_r01_o, 0);
`else
    check("idle_g_x0", bus.g_x0_o, x0);
    check("idle_g_x1", bus.g_x1_o, x1);
    check("idle_g_y0", bus.g_y0_o, y0);
    check("idle_g_y1", bus.g_y1_o, y1);
    check("idle_g_r01", bus.g_r01_o, r);
`endif
  endtask

  // One full operation; entered and left at posedge+1/+2 with the DUT idle.
  task automatic run_op(input logic [W-1:0] x0, x1, y0, y1, r, input int stall, input int hold);
    logic [W-1:0] sq0, sq1;
    int lat;
    bus.x0_i = x0; bus.x1_i = x1; bus.y0_i = y0; bus.y1_i = y1; bus.rnd_i = r;
    bus.in_valid_i = 1'b1;
    bus.rnd_valid_i = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      check("stall_in_ready", bus.in_ready_o, 0);
      check("stall_rnd_ready", bus.rnd_ready_o, 1);
      check("stall_busy", bus.busy_o, 0);
      step();
    end
    bus.rnd_valid_i = 1'b1;
    #1;
    check("in_ready", bus.in_ready_o, 1);
    check("rnd_ready", bus.rnd_ready_o, 1);
    step();
    lat = 0;
    while (!bus.out_valid_o && lat < 8) begin
      check("busy_op", bus.busy_o, 1);
      check("in_ready_op", bus.in_ready_o, 0);
      check("rnd_ready_op", bus.rnd_ready_o, 0);
      check("g_r01_op", bus.g_r01_o, r);
      check("g_x0_op", bus.g_x0_o, x0);
      check("g_x1_op", bus.g_x1_o, x1);
      check("g_y0_op", bus.g_y0_o, y0);
      check("g_y1_op", bus.g_y1_o, y1);
      step();
      lat++;
    end
    check("latency", lat, 3);
    check("result", bus.q0_o ^ bus.q1_o, (x0 ^ x1) & (y0 ^ y1));
    check("busy_done", bus.busy_o, 0);
    check_idle_g(x0, x1, y0, y1, r);
    sq0 = bus.q0_o;
    sq1 = bus.q1_o;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", bus.out_valid_o, 1);
      check("hold_q0", bus.q0_o, sq0);
      check("hold_q1", bus.q1_o, sq1);
      check("hold_in_ready", bus.in_ready_o, 0);
      step();
    end
    bus.out_ready_i = 1'b1;
    #1;
    check("hs_in_ready", bus.in_ready_o, 0);
    check("hs_rnd_ready", bus.rnd_ready_o, 0);
    step();
    bus.in_valid_i = 1'b0;
    bus.rnd_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    exp_cnt = (exp_cnt >= 16'hFFFF) ? 16'hFFFF : exp_cnt + 1;
    #1;
    check("valid_cleared", bus.out_valid_o, 0);
    check("op_cnt", bus.op_cnt_o, exp_cnt);
  endtask

  logic [W-1:0] rx0, rx1, ry0, ry1, rr, prev_r;

  initial begin
    bus.in_valid_i = 1'b1;
    bus.rnd_valid_i = 1'b1;
    bus.out_ready_i = 1'b0;
    bus.x0_i = '0; bus.x1_i = '0; bus.y0_i = '0; bus.y1_i = '0; bus.rnd_i = '0;

    // Reset held with both valids high
    repeat (2) @(posedge clk);
    #1;
    check("rst_g_rst", bus.g_rst_o, 1);
    check("rst_busy", bus.busy_o, 0);
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_q0", bus.q0_o, 0);
    check("rst_q1", bus.q1_o, 0);
    check("rst_op_cnt", bus.op_cnt_o, 0);
    check("rst_in_ready", bus.in_ready_o, 0);
    check("rst_rnd_ready", bus.rnd_ready_o, 0);
    check("rst_g_x0", bus.g_x0_o, 0);
    check("rst_g_r01", bus.g_r01_o, 0);
    bus.in_valid_i = 1'b0;
    bus.rnd_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_g_rst_high", bus.g_rst_o, 1);
    step();
    check("rel_g_rst_low", bus.g_rst_o, 0);
    exp_cnt = 0;

    // Directed: X=0xF0, Y=0x3C -> 0x30
    run_op(8'hA5, 8'h55, 8'h0F, 8'h33, 8'h5A, 0, 0);
    check("directed_cnt", bus.op_cnt_o, 1);

    // Randomness withheld for 10 cycles, then same-cycle accept
    run_op(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 10, 0);

    // Result back-pressured for 6 cycles, then immediate next operation
    run_op(8'hFF, 8'h0F, 8'hC3, 8'h3C, 8'h77, 0, 6);
    run_op(8'h81, 8'h18, 8'hE7, 8'h7E, 8'h24, 0, 0);

    // Random back-to-back operations with fresh randomness each time
    prev_r = 8'h24;
    for (int n = 0; n < 8; n++) begin
      rx0 = 8'($urandom); rx1 = 8'($urandom);
      ry0 = 8'($urandom); ry1 = 8'($urandom);
      rr = 8'($urandom);
      while (rr == prev_r) rr = 8'($urandom);
      prev_r = rr;
      run_op(rx0, rx1, ry0, ry1, rr, $urandom_range(2, 0), $urandom_range(3, 0));
    end

    // Reset in HOLD aborts the operation
    bus.x0_i = 8'h3C; bus.x1_i = 8'hC3; bus.y0_i = 8'h5A; bus.y1_i = 8'hA5; bus.rnd_i = 8'h11;
    bus.in_valid_i = 1'b1;
    bus.rnd_valid_i = 1'b1;
    #1;
    check("abort_in_ready", bus.in_ready_o, 1);
    step();
    step();
    check("abort_busy_hold", bus.busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("abort_g_rst", bus.g_rst_o, 1);
    check("abort_busy", bus.busy_o, 0);
    check("abort_valid", bus.out_valid_o, 0);
    check("abort_g_r01", bus.g_r01_o, 0);
    check("abort_in_ready_rst", bus.in_ready_o, 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_rel_g_rst", bus.g_rst_o, 1);
    check("abort_rel_in_ready", bus.in_ready_o, 0);
    step();
    bus.in_valid_i = 1'b0;
    bus.rnd_valid_i = 1'b0;
    check("abort_g_rst_clr", bus.g_rst_o, 0);
    check("abort_no_accept", bus.busy_o, 0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_valid", bus.out_valid_o, 0);
      step();
    end
    exp_cnt = 0;
    check("abort_op_cnt", bus.op_cnt_o, exp_cnt);

    // Counter saturation
    force dut.op_cnt_q = 16'hFFFC;
    #1;
    release dut.op_cnt_q;
    exp_cnt = 16'hFFFC;
    #1;
    check("preload_cnt", bus.op_cnt_o, exp_cnt);
    run_op(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 0, 0);
    run_op(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 0, 0);
    check("cnt_fffe", bus.op_cnt_o, 16'hFFFE);
    run_op(8'hAA, 8'h55, 8'hF0, 8'h0F, 8'h66, 0, 1);
    run_op(8'h5A, 8'hA5, 8'hCC, 8'h33, 8'h99, 0, 0);
    run_op(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h42, 0, 2);
    check("cnt_sat", bus.op_cnt_o, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/isw_and_seq.md
ISW_AND_SEQ -- requirements
Module: isw_and_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bit width of every share, randomness and result bus.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1): operand handshake.
REQ-005 SHALL have ports x0_i, x1_i, y0_i, y1_i, each input, WIDTH: operand shares, X = x0^x1 and Y = y0^y1.
REQ-006 SHALL have ports rnd_valid_i (input, 1), rnd_ready_o (output, 1) and rnd_i (input, WIDTH): fresh-randomness handshake and data.
REQ-007 SHALL have ports g_x0_o, g_x1_o, g_y0_o, g_y1_o and g_r01_o, each output, WIDTH: drive the 2-share ISW AND gadget.
REQ-008 SHALL have port g_rst_o, output, 1 bit: active-high synchronous reset to the gadget.
REQ-009 SHALL have ports g_q0_i and g_q1_i, each input, WIDTH: gadget result shares.
REQ-010 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), q0_o (output, WIDTH) and q1_o (output, WIDTH): result handshake and shares.
REQ-011 SHALL have ports busy_o (output, 1) and op_cnt_o (output, 16): status.

Function
REQ-012 SHALL implement the FSM states IDLE, ISSUE, HOLD and DONE.
REQ-013 In IDLE with out_valid_o low, SHALL assert in_ready_o iff rnd_valid_i is high, and SHALL assert rnd_ready_o iff in_valid_i is high; operand and randomness therefore transfer jointly.
REQ-014 On a joint transfer, SHALL latch x0/x1/y0/y1/rnd into internal registers and go to ISSUE.
REQ-015 SHALL make the transitions ISSUE->HOLD, HOLD->DONE and DONE->IDLE unconditionally, one cycle each.
REQ-016 In ISSUE, HOLD and DONE, SHALL drive the g_* outputs from the latched registers, held constant across all three cycles; g_r01_o must remain stable through DONE because the gadget uses it combinationally in its output.
REQ-017 At the DONE->IDLE edge, SHALL register g_q0_i/g_q1_i into q0_o/q1_o and set out_valid_o.
REQ-018 Latency SHALL be exactly 3 cycles from the accept edge to out_valid_o high.
REQ-019 SHALL hold q0_o/q1_o stable while out_valid_o && !out_ready_i.
REQ-020 SHALL clear out_valid_o on out_valid_o && out_ready_i.
REQ-021 No new accept SHALL occur in a cycle where out_valid_o is high, even if out_ready_i is high; maximum throughput is one operation per 5 cycles.
REQ-022 SHALL consume each randomness word exactly once, and never reuse it for a later operation.
REQ-023 busy_o SHALL be high iff the state is not IDLE.
REQ-024 op_cnt_o SHALL increment by 1 on each result handshake and saturate at 0xFFFF (no wrap).
REQ-025 SHALL ignore in_valid_i/rnd_valid_i outside IDLE; both ready outputs stay low there.

Reset
REQ-026 While rst_ni is low, SHALL hold: state IDLE, out_valid_o=0, q0_o=q1_o=0, op_cnt_o=0, busy_o=0, in_ready_o=rnd_ready_o=0, all g_* data outputs 0, internal registers 0.
REQ-027 SHALL set g_rst_o=1 asynchronously on reset, keep it high for the first clock edge after rst_ni deasserts, and then clear it; no accept SHALL occur while g_rst_o is high.
REQ-028 Reset asserted mid-operation SHALL abort the operation, discard the partial result and produce no out_valid_o.

Configuration
REQ-029 With macro ISW_SEQ_ZERO_IDLE_EN defined, g_x0_o, g_x1_o, g_y0_o, g_y1_o and g_r01_o SHALL be driven to 0 in IDLE, so no share lingers at the gadget.
REQ-030 Without ISW_SEQ_ZERO_IDLE_EN, these outputs SHALL hold the last latched values in IDLE; all other behaviour is identical.

Verification
REQ-031 Reset release, then X=0xF0 (x0=0xA5, x1=0x55), Y=0x3C (y0=0x0F, y1=0x33), rnd=0x5A -> out_valid_o 3 cycles after accept, q0^q1=0x30, op_cnt_o=1.
REQ-032 in_valid_i high with rnd_valid_i low for 10 cycles -> in_ready_o=0 and busy_o=0 throughout; raise rnd_valid_i -> accept in the same cycle.
REQ-033 out_ready_i low for 6 cycles after a result -> q0_o/q1_o stable, no accept; out_ready_i=1 -> out_valid_o falls, next accept is possible on the following cycle.
REQ-034 rst_ni pulsed low in HOLD -> out_valid_o never rises, g_rst_o high for one edge after release, op_cnt_o=0.
REQ-035 Back-to-back operations with g_r01_o monitored -> constant over ISSUE/HOLD/DONE, new rnd value each operation; g_* equal 0 in IDLE iff ISW_SEQ_ZERO_IDLE_EN.
REQ-036 Preload op_cnt to 0xFFFE via 2 forced handshakes -> after 3 more results op_cnt_o=0xFFFF.
